// File: rtl/mult_sequencer.sv
// mult_sequencer: iterative 32x32 -> 64 shift-add multiplier feeding the HI/LO pair.
// One accepted request (start & ~flush, in IDLE or DONE) runs 32 shift-add steps in RUN;
// HI/LO are written on the last RUN edge and done pulses for the following DONE cycle.
// Optional feature macro: MULT_SIGNED_EN (signed MULT via magnitudes plus a final negate);
// without it is_signed is ignored and every operation is unsigned.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start, flush    - multiply request from E stage, qualified by E-stage flush
//   is_signed       - 1 = MULT, 0 = MULTU
//   op_a, op_b      - multiplicand / multiplier (32 bit)
//   rd_hilo         - MFHI/MFLO present in E stage
//   busy, done      - RUN indicator, one-cycle completion pulse
//   stall_req       - combinational stall request to the hazard unit
//   hi, lo          - HI / LO registers
module mult_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        rd_hilo,
  output logic        busy,
  output logic        done,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DataW = 32;
  localparam int unsigned ProdW = 64;
  localparam int unsigned CntW  = 6;
  localparam logic [CntW-1:0] LastStep = CntW'(DataW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT              state;
  stateT              nextState;
  logic               acc;
  logic               signedMode;
  logic               negIn;
  logic [DataW-1:0]   magA;
  logic [DataW-1:0]   magB;
  logic [ProdW-1:0]   mcand;
  logic [DataW-1:0]   mplier;
  logic [ProdW-1:0]   prod;
  logic [ProdW-1:0]   stepSum;
  logic [CntW-1:0]    cnt;
  logic               negRes;

  assign acc = start & ~flush;

`ifdef MULT_SIGNED_EN
  assign signedMode = is_signed;
`else
  // is_signed stays on the port but has no effect in the unsigned-only build
  logic unusedIsSigned;
  assign unusedIsSigned = is_signed;
  assign signedMode     = 1'b0;
`endif

  // Operand magnitudes; 0x80000000 negates to itself, which read unsigned is 2^31
  assign magA  = (signedMode & op_a[DataW-1]) ? DataW'(-op_a) : op_a;
  assign magB  = (signedMode & op_b[DataW-1]) ? DataW'(-op_b) : op_b;
  assign negIn = signedMode & (op_a[DataW-1] ^ op_b[DataW-1]);

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
  assign stepSum = prod + (mplier[0] ? mcand : ProdW'(0));

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign stall_req = busy & (rd_hilo | start);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; start is ignored while RUN
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (acc) nextState = RUN;
      RUN:     if (cnt == LastStep) nextState = DONE;
      DONE:    nextState = acc ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath: operand latch on accept, iteration in RUN, HI/LO write on the last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      negRes <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == RUN) begin
      prod   <= stepSum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CntW'(1);
      if (cnt == LastStep) begin
        {hi, lo} <= negRes ? ProdW'(-stepSum) : stepSum;
      end
    end else if (acc) begin
      mcand  <= ProdW'(magA);
      mplier <= magB;
      prod   <= '0;
      cnt    <= '0;
      negRes <= negIn;
    end
  end

endmodule
